// File: rtl/player_shot.sv
// Player laser: launches one shot per fire press from the cannon centre, steps it up once per
// frame, retires it on hit or at the screen top, then holds off re-arm for a frame cooldown.
module player_shot #(
  parameter int SPRITE_W        = 32,
  parameter int SHOT_W          = 2,
  parameter int SHOT_H          = 8,
  parameter int SHOT_STEP       = 4,
  parameter int TOP_Y           = 0,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       frame,
  input  logic       fire,
  input  logic       hit,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic [9:0] shot_x,
  output logic [9:0] shot_y,
  output logic       shot_active,
  output logic       shot_fired
);

  localparam int CW = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  localparam logic [9:0]    X_OFF      = 10'(SPRITE_W / 2 - SHOT_W / 2);
  localparam logic [9:0]    H_OFF      = 10'(SHOT_H);
  localparam logic [9:0]    STEP       = 10'(SHOT_STEP);
  localparam logic [9:0]    LAUNCH_MIN = 10'(TOP_Y + SHOT_H);
  localparam logic [9:0]    RETIRE_LT  = 10'(TOP_Y + SHOT_STEP);
  localparam logic [CW-1:0] COOL_INIT  = CW'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

  state_t        state;
  logic          pending;
  logic          fire_q;
  logic [CW-1:0] cool_cnt;
  logic          fire_rise;
  logic          launch_req;
  logic          retire;

  assign fire_rise  = fire & ~fire_q;
  // An edge arriving in the same cycle as the frame strobe still launches.
  assign launch_req = pending | fire_rise;
  // Compare before subtracting so shot_y never wraps past the top.
  assign retire     = hit | (frame & (shot_y < RETIRE_LT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= 1'b0;
      fire_q      <= 1'b0;
      cool_cnt    <= '0;
      shot_x      <= '0;
      shot_y      <= '0;
      shot_active <= 1'b0;
      shot_fired  <= 1'b0;
    end else if (clr) begin
      state       <= IDLE;
      pending     <= 1'b0;
      fire_q      <= 1'b0;
      cool_cnt    <= '0;
      shot_x      <= '0;
      shot_y      <= '0;
      shot_active <= 1'b0;
      shot_fired  <= 1'b0;
    end else begin
      fire_q     <= fire;
      shot_fired <= 1'b0;
      case (state)
        IDLE: begin
          if (frame && launch_req) begin
            pending <= 1'b0;
            if (player_y >= LAUNCH_MIN) begin
              shot_x      <= player_x + X_OFF;
              shot_y      <= player_y - H_OFF;
              shot_active <= 1'b1;
              shot_fired  <= 1'b1;
              state       <= FLYING;
            end
          end else if (fire_rise) begin
            pending <= 1'b1;
          end
        end
        FLYING: begin
          if (retire) begin
            shot_active <= 1'b0;
            cool_cnt    <= COOL_INIT;
            state       <= COOLDOWN;
          end else if (frame) begin
            shot_y <= shot_y - STEP;
          end
        end
        COOLDOWN: begin
          if (cool_cnt == '0)
            state <= IDLE;
          else if (frame)
            cool_cnt <= cool_cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_player_shot.sv
// Self-checking bench for player_shot: directed scenarios plus randomized play against a
// frame-count model of the shot (launch height, frames flown, frames of cooldown left).
module tb_player_shot;
  localparam int SPRITE_W = 32, SHOT_W = 2, SHOT_H = 8, SHOT_STEP = 4, TOP_Y = 0, COOL = 8;

  logic       clk = 1'b0;
  logic       rst, clr, frame, fire, hit;
  logic [9:0] player_x, player_y;
  logic [9:0] shot_x, shot_y;
  logic       shot_active, shot_fired;

  int errors = 0;
  int checks = 0;

  player_shot #(.SPRITE_W(SPRITE_W), .SHOT_W(SHOT_W), .SHOT_H(SHOT_H), .SHOT_STEP(SHOT_STEP),
                .TOP_Y(TOP_Y), .COOLDOWN_FRAMES(COOL)) dut (
    .clk(clk), .rst(rst), .clr(clr), .frame(frame), .fire(fire), .hit(hit),
    .player_x(player_x), .player_y(player_y), .shot_x(shot_x), .shot_y(shot_y),
    .shot_active(shot_active), .shot_fired(shot_fired));

  always #5 clk = ~clk;

  // Model: shot described by launch height and frames flown; phase 0 ready, 1 in air, 2 cooling.
  int m_phase, m_sx, m_ly, m_flown, m_left;
  bit m_req, m_prev, m_active, m_fired;

  function automatic int m_y();
    return m_ly - SHOT_STEP * m_flown;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_sx = 0; m_ly = 0; m_flown = 0; m_left = 0;
    m_req = 0; m_prev = 0; m_active = 0; m_fired = 0;
  endtask

  task automatic model_step();
    bit rise;
    if (rst || clr) begin model_reset(); return; end
    rise    = fire && !m_prev;
    m_prev  = fire;
    m_fired = 0;
    if (m_phase == 0) begin
      if (frame && (m_req || rise)) begin
        m_req = 0;
        if (int'(player_y) >= TOP_Y + SHOT_H) begin
          m_sx = int'(player_x) + SPRITE_W / 2 - SHOT_W / 2;
          m_ly = int'(player_y) - SHOT_H;
          m_flown = 0; m_active = 1; m_fired = 1; m_phase = 1;
        end
      end else if (rise) m_req = 1;
    end else if (m_phase == 1) begin
      if (hit || (frame && m_y() < TOP_Y + SHOT_STEP)) begin
        m_active = 0; m_left = COOL; m_phase = 2;
      end else if (frame) m_flown++;
    end else begin
      if (m_left == 0) m_phase = 0;
      else if (frame) m_left--;
    end
  endtask

  task automatic cyc(input bit f, input bit fr, input bit h, input bit c);
    fire = f; frame = fr; hit = h; clr = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic frame_pulse(input bit f);
    cyc(f, 1, 0, 0);
    cyc(f, 0, 0, 0);
  endtask

  // Bring the block back to ready: hit any live shot, then run frames until cooldown ends.
  task automatic settle();
    int n = 0;
    if (m_phase == 1) cyc(0, 0, 1, 0);
    while (m_phase != 0 && n < 40) begin frame_pulse(0); n++; end
    cyc(0, 0, 0, 0);
    checks++;
    if (m_phase != 0 || shot_active !== 1'b0) begin
      errors++;
      $display("FAIL settle: active=%0b phase=%0d after %0d frames, required idle", shot_active, m_phase, n);
    end
  endtask

  task automatic test_reset();
    rst = 1; clr = 0; fire = 0; frame = 0; hit = 0; player_x = 10'd300; player_y = 10'd440;
    model_reset();
    #12;
    checks++;
    if (shot_x !== 0 || shot_y !== 0 || shot_active !== 0 || shot_fired !== 0) begin
      errors++;
      $display("FAIL reset_state: x=%0d y=%0d act=%0b fired=%0b, required all 0", shot_x, shot_y, shot_active, shot_fired);
    end
    @(negedge clk); rst = 0;
    cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
    frame_pulse(1); frame_pulse(1);
    checks++;
    if (shot_active !== 1 || shot_y !== 10'd424) begin
      errors++;
      $display("FAIL pre_reset_flight: act=%0b y=%0d, required 1 / 424", shot_active, shot_y);
    end
    @(negedge clk); #2 rst = 1; #1;
    checks++;
    if (shot_x !== 0 || shot_y !== 0 || shot_active !== 0 || shot_fired !== 0) begin
      errors++;
      $display("FAIL async_reset: x=%0d y=%0d act=%0b, required all 0 before clock edge", shot_x, shot_y, shot_active);
    end
    model_reset();
    cyc(1, 1, 0, 0);
    rst = 0;
    cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
    checks++;
    if (shot_active !== 1 || shot_fired !== 1 || shot_x !== 10'd315 || shot_y !== 10'd432) begin
      errors++;
      $display("FAIL relaunch_after_reset: act=%0b fired=%0b x=%0d y=%0d, required 1/1/315/432", shot_active, shot_fired, shot_x, shot_y);
    end
    cyc(1, 0, 0, 1);
    checks++;
    if (shot_active !== 0 || shot_x !== 0 || shot_y !== 0) begin
      errors++;
      $display("FAIL sync_clear: act=%0b x=%0d y=%0d, required all 0", shot_active, shot_x, shot_y);
    end
  endtask

  task automatic test_launch_flight_top();
    bit exp_f;
    settle();
    player_x = 10'd300; player_y = 10'd440;
    cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
    checks++;
    if (shot_x !== 10'd315 || shot_y !== 10'd432 || shot_active !== 1 || shot_fired !== 1) begin
      errors++;
      $display("FAIL launch: x=%0d y=%0d act=%0b fired=%0b, required 315/432/1/1", shot_x, shot_y, shot_active, shot_fired);
    end
    player_x = 10'd50;
    cyc(1, 0, 0, 0);
    checks++;
    if (shot_fired !== 0 || shot_x !== 10'd315) begin
      errors++;
      $display("FAIL fired_pulse_len: fired=%0b x=%0d, required 0 / 315", shot_fired, shot_x);
    end
    for (int i = 0; i < 108; i++) frame_pulse(1);
    checks++;
    if (shot_y !== 0 || shot_active !== 1) begin
      errors++;
      $display("FAIL top_reached: y=%0d act=%0b, required 0 / 1", shot_y, shot_active);
    end
    frame_pulse(1);
    checks++;
    if (shot_active !== 0 || shot_y !== 0) begin
      errors++;
      $display("FAIL top_retire: act=%0b y=%0d, required 0 / 0", shot_active, shot_y);
    end
    for (int k = 1; k <= 9; k++) begin
      cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
      exp_f = (k == 9);
      checks++;
      if (shot_fired !== exp_f || shot_active !== exp_f) begin
        errors++;
        $display("FAIL cooldown_frame_%0d: fired=%0b act=%0b, required %0b", k, shot_fired, shot_active, exp_f);
      end
    end
  endtask

  task automatic test_hit();
    settle();
    player_x = 10'd100; player_y = 10'd108;
    cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    checks++;
    if (shot_active !== 0 || shot_y !== 10'd100 || shot_x !== 10'd115) begin
      errors++;
      $display("FAIL hit_with_frame: act=%0b y=%0d x=%0d, required 0/100/115", shot_active, shot_y, shot_x);
    end
    settle();
    cyc(0, 0, 1, 0); cyc(0, 1, 1, 0);
    checks++;
    if (shot_active !== 0 || shot_fired !== 0 || shot_y !== 10'd100) begin
      errors++;
      $display("FAIL hit_while_idle: act=%0b fired=%0b y=%0d, required 0/0/100", shot_active, shot_fired, shot_y);
    end
  endtask

  task automatic test_held_fire();
    int pulses = 0;
    settle();
    player_x = 10'd200; player_y = 10'd440;
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      cyc(1, 1, 0, 0); pulses += shot_fired;
      cyc(1, 0, 0, 0); pulses += shot_fired;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL held_fire: pulses=%0d, required 1", pulses);
    end
  endtask

  task automatic test_refuse();
    settle();
    player_x = 10'd10; player_y = 10'd4;
    cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
    checks++;
    if (shot_active !== 0 || shot_fired !== 0) begin
      errors++;
      $display("FAIL refuse_low: act=%0b fired=%0b, required 0/0", shot_active, shot_fired);
    end
    player_y = 10'd440;
    frame_pulse(1);
    checks++;
    if (shot_active !== 0 || shot_fired !== 0) begin
      errors++;
      $display("FAIL refuse_pending_cleared: act=%0b fired=%0b, required 0/0", shot_active, shot_fired);
    end
    player_y = 10'd8;
    cyc(0, 0, 0, 0); cyc(1, 1, 0, 0);
    checks++;
    if (shot_active !== 1 || shot_y !== 10'd0 || shot_x !== 10'd25) begin
      errors++;
      $display("FAIL launch_at_limit: act=%0b y=%0d x=%0d, required 1/0/25", shot_active, shot_y, shot_x);
    end
    frame_pulse(1);
    checks++;
    if (shot_active !== 0) begin
      errors++;
      $display("FAIL retire_at_limit: act=%0b, required 0", shot_active);
    end
  endtask

  task automatic test_random();
    bit f = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) f = ~f;
      if ($urandom_range(0, 49) == 0) player_x = 10'($urandom_range(0, 640 - SPRITE_W));
      if ($urandom_range(0, 49) == 0)
        player_y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 479));
      cyc(f, $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 799) == 0);
      checks++;
      if (shot_x !== 10'(m_sx) || shot_y !== 10'(m_y()) || shot_active !== m_active || shot_fired !== m_fired) begin
        errors++;
        $display("FAIL random_cyc_%0d: x=%0d y=%0d act=%0b fired=%0b, required %0d/%0d/%0b/%0b",
                 i, shot_x, shot_y, shot_active, shot_fired, m_sx, m_y(), m_active, m_fired);
      end
    end
  endtask

  initial begin
    test_reset();
    test_launch_flight_top();
    test_hit();
    test_held_fire();
    test_refuse();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
